// File: rtl/ddr3_cmd_seq.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_seq
//
// Per-request DDR3 command sequencer. It takes one classified request
// (row hit / miss / empty) from the bank row-control stage and issues the
// matching PRE / ACT / RD / WR sequence toward the PHY command port. It
// enforces tRP and tRCD with a shared wait counter. Refresh requests are
// serviced as precharge-all, then REF, then a tRFC wait.
//
// Optional feature macro: DDR3_CMD_SEQ_REF_EN
//   defined     : refresh path (RPRE/RWAIT_RP/REF/WAIT_RFC, ref_ack) built
//   not defined : c_ref ignored, refresh states absent, ref_ack held at 0
//
// Ports
//   ddr3_mcb_clk      clock, rising edge
//   ddr3_mcb_rst      asynchronous active-high reset
//   row_hit0/row_miss0/row_empty0  request classification (sampled in IDLE)
//   ddr3_mcb_ba/ra/ca request bank / row / column
//   ddr3_mcb_wr_n     1 = read, 0 = write
//   c_ref             refresh request (level)
//   cmd_ready         PHY accepts the presented command
//   cmd_valid/cmd_code/cmd_ba/cmd_addr  registered command output
//   ddr3_mcb_i_ready  idle, request accepted this cycle
//   rw_done           one-cycle pulse after the RD/WR handshake
//   ref_ack           one-cycle pulse when the refresh wait has expired
// ---------------------------------------------------------------------------
module ddr3_cmd_seq #(
    parameter int MCB_B_W = 3,
    parameter int MCB_R_W = 13,
    parameter int MCB_C_W = 10,
    parameter int T_RP    = 6,
    parameter int T_RCD   = 6,
    parameter int T_RFC   = 88,
    parameter int CNT_W   = 8
) (
    input  logic               ddr3_mcb_clk,
    input  logic               ddr3_mcb_rst,
    input  logic               row_hit0,
    input  logic               row_miss0,
    input  logic               row_empty0,
    input  logic [MCB_B_W-1:0] ddr3_mcb_ba,
    input  logic [MCB_R_W-1:0] ddr3_mcb_ra,
    input  logic [MCB_C_W-1:0] ddr3_mcb_ca,
    input  logic               ddr3_mcb_wr_n,
    input  logic               c_ref,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output logic [2:0]         cmd_code,
    output logic [MCB_B_W-1:0] cmd_ba,
    output logic [MCB_R_W-1:0] cmd_addr,
    output logic               ddr3_mcb_i_ready,
    output logic               rw_done,
    output logic               ref_ack
);

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_RD  = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b100;
`ifdef DDR3_CMD_SEQ_REF_EN
    localparam logic [2:0] CMD_REF = 3'b101;
    // A10 high selects precharge-all
    localparam logic [MCB_R_W-1:0] PREA_ADDR = MCB_R_W'(1) << 10;
`endif

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PRE      = 4'd1,
        S_WAIT_RP  = 4'd2,
        S_ACT      = 4'd3,
        S_WAIT_RCD = 4'd4,
        S_RW       = 4'd5
`ifdef DDR3_CMD_SEQ_REF_EN
        ,
        S_RPRE     = 4'd6,
        S_RWAIT_RP = 4'd7,
        S_REF      = 4'd8,
        S_WAIT_RFC = 4'd9
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MCB_B_W-1:0] ba_q, ba_d;
    logic [MCB_R_W-1:0] ra_q, ra_d;
    logic [MCB_C_W-1:0] ca_q, ca_d;
    logic               wr_n_q, wr_n_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [2:0]         cmd_code_q, cmd_code_d;
    logic [MCB_B_W-1:0] cmd_ba_q, cmd_ba_d;
    logic [MCB_R_W-1:0] cmd_addr_q, cmd_addr_d;
    logic               i_ready_q, i_ready_d;
    logic               rw_done_q, rw_done_d;
    logic               ref_ack_q, ref_ack_d;

    logic hs;
    logic any_req;
    logic ref_go;

    assign hs      = cmd_valid_q & cmd_ready;
    assign any_req = row_hit0 | row_miss0 | row_empty0;

`ifdef DDR3_CMD_SEQ_REF_EN
    assign ref_go = c_ref;
`else
    logic unused_c_ref;
    assign unused_c_ref = c_ref;
    assign ref_go       = 1'b0;
    localparam int unused_t_rfc = T_RFC;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ba_d        = ba_q;
        ra_d        = ra_q;
        ca_d        = ca_q;
        wr_n_d      = wr_n_q;
        rw_done_d   = 1'b0;
        ref_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Refresh outranks any request; a request seen together
                // with c_ref is dropped, not queued.
                if (!ref_go && any_req) begin
                    ba_d   = ddr3_mcb_ba;
                    ra_d   = ddr3_mcb_ra;
                    ca_d   = ddr3_mcb_ca;
                    wr_n_d = ddr3_mcb_wr_n;
                    if (row_miss0)       state_d = S_PRE;
                    else if (row_empty0) state_d = S_ACT;
                    else                 state_d = S_RW;
                end
`ifdef DDR3_CMD_SEQ_REF_EN
                if (ref_go) state_d = S_RPRE;
`endif
            end
            S_PRE: begin
                if (hs) begin
                    // A one-cycle wait is satisfied by the handshake edge itself
                    if (T_RP == 1) begin
                        state_d = S_ACT;
                    end else begin
                        state_d = S_WAIT_RP;
                        cnt_d   = CNT_W'(T_RP - 1);
                    end
                end
            end
            S_WAIT_RP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_ACT;
            end
            S_ACT: begin
                if (hs) begin
                    if (T_RCD == 1) begin
                        state_d = S_RW;
                    end else begin
                        state_d = S_WAIT_RCD;
                        cnt_d   = CNT_W'(T_RCD - 1);
                    end
                end
            end
            S_WAIT_RCD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_RW;
            end
            S_RW: begin
                if (hs) begin
                    state_d   = S_IDLE;
                    rw_done_d = 1'b1;
                end
            end
`ifdef DDR3_CMD_SEQ_REF_EN
            S_RPRE: begin
                if (hs) begin
                    if (T_RP == 1) begin
                        state_d = S_REF;
                    end else begin
                        state_d = S_RWAIT_RP;
                        cnt_d   = CNT_W'(T_RP - 1);
                    end
                end
            end
            S_RWAIT_RP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_REF;
            end
            S_REF: begin
                if (hs) begin
                    if (T_RFC == 1) begin
                        state_d   = S_IDLE;
                        ref_ack_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_RFC;
                        cnt_d   = CNT_W'(T_RFC - 1);
                    end
                end
            end
            S_WAIT_RFC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d   = S_IDLE;
                    ref_ack_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Command outputs are a function of the state being entered, so
        // they are registered alongside it and stay stable while stalled.
        cmd_valid_d = 1'b0;
        cmd_code_d  = CMD_NOP;
        cmd_ba_d    = '0;
        cmd_addr_d  = '0;
        case (state_d)
            S_PRE: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = CMD_PRE;
                cmd_ba_d    = ba_d;
            end
            S_ACT: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = CMD_ACT;
                cmd_ba_d    = ba_d;
                cmd_addr_d  = ra_d;
            end
            S_RW: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = wr_n_d ? CMD_RD : CMD_WR;
                cmd_ba_d    = ba_d;
                cmd_addr_d  = {{(MCB_R_W - MCB_C_W){1'b0}}, ca_d};
            end
`ifdef DDR3_CMD_SEQ_REF_EN
            S_RPRE: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = CMD_PRE;
                cmd_addr_d  = PREA_ADDR;
            end
            S_REF: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = CMD_REF;
            end
`endif
            default: ;
        endcase

        i_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge ddr3_mcb_clk or posedge ddr3_mcb_rst) begin
        if (ddr3_mcb_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ba_q        <= '0;
            ra_q        <= '0;
            ca_q        <= '0;
            wr_n_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NOP;
            cmd_ba_q    <= '0;
            cmd_addr_q  <= '0;
            i_ready_q   <= 1'b1;
            rw_done_q   <= 1'b0;
            ref_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ba_q        <= ba_d;
            ra_q        <= ra_d;
            ca_q        <= ca_d;
            wr_n_q      <= wr_n_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_addr_q  <= cmd_addr_d;
            i_ready_q   <= i_ready_d;
            rw_done_q   <= rw_done_d;
            ref_ack_q   <= ref_ack_d;
        end
    end

    assign cmd_valid        = cmd_valid_q;
    assign cmd_code         = cmd_code_q;
    assign cmd_ba           = cmd_ba_q;
    assign cmd_addr         = cmd_addr_q;
    assign ddr3_mcb_i_ready = i_ready_q;
    assign rw_done          = rw_done_q;
    assign ref_ack          = ref_ack_q;

endmodule

// File: doc/ddr3_cmd_seq.md
# ddr3_cmd_seq

Per-request DDR3 command sequencer sitting directly downstream of the bank row-control stage. It consumes the registered row classification (hit/miss/empty) together with the bank, row and column address and read/write direction. It emits the PRE/ACT/RD/WR command sequence toward the PHY command interface, enforcing tRP and tRCD. It also services refresh requests with precharge-all followed by REF, enforcing tRFC.

## Interface
Parameters:
- MCB_B_W, 3, bank address width
- MCB_R_W, 13, row address width
- MCB_C_W, 10, column address width (MCB_C_W ≤ MCB_R_W−3)
- T_RP, 6, cycles from PRE handshake to next command valid (≥1)
- T_RCD, 6, cycles from ACT handshake to RD/WR valid (≥1)
- T_RFC, 88, cycles from REF handshake to ref_ack (≥1)
- CNT_W, 8, wait-counter width; must hold max(T_RP, T_RCD, T_RFC)−1

Ports:
- ddr3_mcb_clk  in  1  clock, all logic on rising edge
- ddr3_mcb_rst  in  1  asynchronous, active-high reset
- row_hit0  in  1  request, target row already open
- row_miss0  in  1  request, other row open in bank
- row_empty0  in  1  request, bank idle
- ddr3_mcb_ba  in  MCB_B_W  request bank
- ddr3_mcb_ra  in  MCB_R_W  request row
- ddr3_mcb_ca  in  MCB_C_W  request column
- ddr3_mcb_wr_n  in  1  1 = read, 0 = write
- c_ref  in  1  refresh request, level
- cmd_ready  in  1  PHY accepts command
- cmd_valid  out  1  command present
- cmd_code  out  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF
- cmd_ba  out  MCB_B_W  command bank
- cmd_addr  out  MCB_R_W  row for ACT; zero-extended column for RD/WR; bit 10 = 1 for precharge-all
- ddr3_mcb_i_ready  out  1  sequencer idle and accepting a request
- rw_done  out  1  one-cycle pulse, RD/WR accepted
- ref_ack  out  1  one-cycle pulse, refresh complete

## Operation
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, RPRE, RWAIT_RP, REF, WAIT_RFC.
- IDLE: ddr3_mcb_i_ready=1. Priority order is c_ref, then miss, then empty, then hit. More than one flag set at once is illegal but is resolved by this order.
  - On c_ref: go to RPRE.
  - On a request flag: capture ba/ra/ca/wr_n into internal registers. miss goes to PRE, empty goes to ACT, hit goes to RW.
- Flags outside IDLE are ignored. Upstream must wait for ddr3_mcb_i_ready.
- c_ref asserted while busy is not lost. Being a level, it is serviced on the next IDLE cycle, ahead of any request.
- Command states hold cmd_valid=1 with stable code, bank and address until cmd_valid & cmd_ready. The handshake cycle loads the wait counter with T−1 and moves to the wait state.
- Wait states decrement the counter. When the counter reaches 0, the FSM advances to the next command state:
  - PRE → WAIT_RP → ACT
  - ACT → WAIT_RCD → RW
  - RPRE → RWAIT_RP → REF
- RW issues RD if wr_n=1, WR if wr_n=0, with column in cmd_addr[MCB_C_W−1:0] and all other bits 0. The handshake pulses rw_done on the next cycle and returns to IDLE.
- RPRE issues PRE with cmd_addr[10]=1 and cmd_ba=0. REF issues REF. WAIT_RFC expiry pulses ref_ack and returns to IDLE.
- When cmd_valid=0: cmd_code=NOP, cmd_ba=0, cmd_addr=0.

## Timing
- All outputs are registered.
- Reset values: state IDLE, cmd_valid 0, cmd_code 000, cmd_ba 0, cmd_addr 0, ddr3_mcb_i_ready 1, rw_done 0, ref_ack 0, counter 0.
- Reset mid-sequence aborts immediately and drops cmd_valid asynchronously. No command completion is reported.
- A request sampled in IDLE at cycle N produces cmd_valid at N+1, and ddr3_mcb_i_ready=0 from N+1.
- A handshake at cycle H with wait T gives the next cmd_valid at H+T.
- Hit, cmd_ready=1: RD/WR at N+1, rw_done and ddr3_mcb_i_ready=1 at N+2.
- Empty, cmd_ready=1, T_RCD=6: ACT at N+1, RD/WR at N+7, rw_done at N+8.
- Miss, cmd_ready=1, T_RP=T_RCD=6: PRE N+1, ACT N+7, RD/WR N+13, rw_done N+14.
- Refresh, T_RP=6, T_RFC=88: PREA N+1, REF N+7, ref_ack and IDLE at N+95.
- cmd_ready stall extends the command state cycle by cycle. Wait counters start only at the handshake.

## Configuration
- DDR3_CMD_SEQ_REF_EN defined: the refresh path (RPRE/RWAIT_RP/REF/WAIT_RFC, ref_ack) is present as described.
- Not defined: c_ref is ignored, the refresh states are not built, and ref_ack is tied to 0.

## Test plan
- Reset, then release with no stimulus → ddr3_mcb_i_ready=1, cmd_valid=0, cmd_code=000 for 20 cycles.
- row_empty0 with ba=3, ra=0x0123, ca=0x040, wr_n=1, cmd_ready=1 → ACT ba=3 addr=0x0123 at N+1; RD ba=3 addr=0x0040 at N+7; rw_done at N+8.
- row_miss0, wr_n=0, cmd_ready low for 3 cycles on PRE → PRE held 4 cycles; ACT 6 cycles after the PRE handshake; WR 6 cycles later; rw_done one pulse.
- row_hit0 and c_ref in the same IDLE cycle (REF_EN defined) → PRE with addr=0x0400, REF at +6, ref_ack at REF handshake +88. The hit flag is dropped; a re-presented hit is then served as RD.
- c_ref asserted during WAIT_RCD → current RD completes with rw_done; refresh starts the cycle after returning to IDLE.
- Reset asserted during WAIT_RP → cmd_valid=0 immediately; no ACT issued after release; ddr3_mcb_i_ready=1.
